pin_lockout_controller: RTL and testbench

//  Parametrised PIN-entry access controller: successor to the fixed 4-digit phone security block.

---
 rtl/pin_lockout_controller.sv | 112 +++++++++++
 tb/tb_pin_lockout_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pin_lockout_controller.sv
// pin_lockout_controller: BCD PIN check with valid/ready handshake, failure counting and timed lockout.
// Optional PIN change via NEWPIN is enabled by defining PIN_CHANGE_EN.
module pin_lockout_controller #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCKOUT_CYCLES = 20,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PIN = 16'h8642
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DIGITS*DIGIT_W-1:0]         pin_input,
  input  logic                              pin_valid,
  output logic                              pin_ready,
  input  logic                              change_req,
  output logic                              access_granted,
  output logic                              access_denied,
  output logic                              locked_out,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);
  localparam int PW = DIGITS * DIGIT_W;
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RESULT, LOCKED, NEWPIN} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] att_q, att_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gr_q, gr_d, dn_q, dn_d, chg_q, chg_d;
  logic legal, accept, wr_en, chg_en;
  logic [PW-1:0] stored;
`ifdef PIN_CHANGE_EN
  logic [PW-1:0] pin_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pin_q <= DEFAULT_PIN;
    else if (wr_en) pin_q <= pin_input;
  assign stored = pin_q;
  assign chg_en = 1'b1;
`else
  logic unused_wr;
  assign unused_wr = wr_en;
  assign stored = DEFAULT_PIN;
  assign chg_en = 1'b0;
`endif
  assign pin_ready = reset_n && (state_q == IDLE || state_q == NEWPIN);
  assign accept = pin_valid && pin_ready;
  assign access_granted = gr_q;
  assign access_denied = dn_q;
  assign locked_out = state_q == LOCKED;
  assign attempts_left = att_q;
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (pin_input[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) legal = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    att_d = att_q;
    cnt_d = cnt_q;
    gr_d = 1'b0;
    dn_d = 1'b0;
    chg_d = 1'b0;
    wr_en = 1'b0;
    unique case (state_q)
      IDLE:
        if (accept) begin
          if (legal && pin_input == stored) begin
            gr_d = 1'b1;
            att_d = AW'(MAX_ATTEMPTS);
            chg_d = chg_en && change_req;
            state_d = RESULT;
          end else begin
            // The failure that exhausts the budget goes straight to lockout, skipping RESULT.
            dn_d = 1'b1;
            att_d = att_q - AW'(att_q != '0);
            cnt_d = '0;
            state_d = (att_q <= AW'(1)) ? LOCKED : RESULT;
          end
        end
      RESULT: state_d = chg_q ? NEWPIN : IDLE;
      LOCKED: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
          att_d = AW'(MAX_ATTEMPTS);
        end
      end
      NEWPIN:
        if (accept) begin
          wr_en = legal;
          gr_d = legal;
          dn_d = !legal;
          state_d = RESULT;
        end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      att_q <= AW'(MAX_ATTEMPTS);
      cnt_q <= '0;
      gr_q <= 1'b0;
      dn_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      att_q <= att_d;
      cnt_q <= cnt_d;
      gr_q <= gr_d;
      dn_q <= dn_d;
      chg_q <= chg_d;
    end
endmodule

// File: tb/tb_pin_lockout_controller.sv
// tb_pin_lockout_controller: directed and random stimulus against a cycle-level behavioural model.
module tb_pin_lockout_controller;
  localparam int MAXA = 3;
  localparam int LC = 20;
  localparam logic [15:0] DEF = 16'h8642;
`ifdef PIN_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, pin_valid = 1'b0, change_req = 1'b0;
  logic [15:0] pin_input = '0;
  logic pin_ready, access_granted, access_denied, locked_out;
  logic [1:0] attempts_left;
  int checks = 0, errors = 0;
  logic [15:0] m_pin;
  int m_att, m_lock, m_gr, m_dn;
  bit m_res, m_new, m_pend;

  pin_lockout_controller #(.DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(MAXA),
    .LOCKOUT_CYCLES(LC), .DEFAULT_PIN(DEF)) dut (
    .clk(clk), .reset_n(reset_n), .pin_input(pin_input), .pin_valid(pin_valid),
    .pin_ready(pin_ready), .change_req(change_req), .access_granted(access_granted),
    .access_denied(access_denied), .locked_out(locked_out), .attempts_left(attempts_left));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [15:0] p);
    int v = int'(p);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) % 16) > 9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_pin = DEF; m_att = MAXA; m_lock = 0; m_gr = 0; m_dn = 0;
    m_res = 0; m_new = 0; m_pend = 0;
  endtask

  task automatic check_all();
    chk("ready", int'(pin_ready), int'(!m_res && m_lock == 0));
    chk("granted", int'(access_granted), m_gr);
    chk("denied", int'(access_denied), m_dn);
    chk("locked", int'(locked_out), int'(m_lock > 0));
    chk("attempts", int'(attempts_left), m_att);
  endtask

  // Called at a falling edge: drive one beat, advance the model over the next rising edge, then check.
  task automatic step(input bit v, input logic [15:0] p, input bit c);
    pin_valid = v; pin_input = p; change_req = c;
    m_gr = 0; m_dn = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_att = MAXA;
    end else if (m_res) begin
      m_res = 0; m_new = m_pend; m_pend = 0;
    end else if (v) begin
      if (m_new) begin
        m_new = 0; m_res = 1;
        if (legal(p)) begin m_pin = p; m_gr = 1; end else m_dn = 1;
      end else if (legal(p) && p == m_pin) begin
        m_gr = 1; m_att = MAXA; m_res = 1; m_pend = CHG && c;
      end else begin
        m_dn = 1;
        if (m_att > 0) m_att--;
        if (m_att == 0) m_lock = LC; else m_res = 1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pin_valid = 1'b0;
    #1;
    chk("rst_ready", int'(pin_ready), 0);
    chk("rst_granted", int'(access_granted), 0);
    chk("rst_denied", int'(access_denied), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_attempts", int'(attempts_left), MAXA);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rel_ready", int'(pin_ready), 1);
  endtask

  initial begin
    logic [15:0] p;
    int r;
    m_reset();
    repeat (2) @(negedge clk);
    do_reset();
    step(1, DEF, 0);
    chk("t1_grant", int'(access_granted), 1);
    step(0, 16'h0, 0);
    step(1, 16'h8431, 0);
    chk("t2_att2", int'(attempts_left), 2);
    step(0, 16'h0, 0);
    step(1, 16'h3849, 0);
    step(0, 16'h0, 0);
    step(1, 16'hBC49, 0);
    chk("t3_locked", int'(locked_out), 1);
    chk("t3_att0", int'(attempts_left), 0);
    repeat (LC) step(1, DEF, 0);
    chk("t4_unlocked", int'(locked_out), 0);
    step(1, DEF, 0);
    chk("t4_grant", int'(access_granted), 1);
    step(0, 16'h0, 0);
    step(1, 16'h1111, 0); step(0, 16'h0, 0);
    step(1, 16'h2222, 0); step(0, 16'h0, 0);
    step(1, DEF, 0);
    chk("t5_reload", int'(attempts_left), MAXA);
    step(0, 16'h0, 0);
    repeat (3) begin step(1, 16'hFFFF, 0); step(0, 16'h0, 0); end
    step(0, 16'h0, 0);
    do_reset();
    step(1, DEF, 1); step(0, 16'h0, 0);
    step(1, 16'h1234, 0); step(0, 16'h0, 0);
    step(1, DEF, 0); step(0, 16'h0, 0);
    step(1, 16'h1234, 0); step(0, 16'h0, 0);
    step(1, m_pin, 1); step(0, 16'h0, 0);
    step(1, 16'h12A4, 0); step(0, 16'h0, 0);
    step(1, m_pin, 0); step(0, 16'h0, 0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 700 == 0) begin
        do_reset();
        continue;
      end
      r = $urandom % 10;
      if (r < 3) p = m_pin;
      else if (r < 5) p = DEF;
      else if (r < 7) begin
        p = '0;
        for (int i = 0; i < 4; i++) p = p | 16'(($urandom % 10) << (4 * i));
      end else p = 16'($urandom);
      step($urandom % 2 == 0, p, $urandom % 3 == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
